// File: rtl/uart_rx_buffered.sv
// UART receiver with a small receive FIFO and single-cycle error pulses.
// Optional parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 72,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx,
  output logic [DATA_BITS-1:0]               m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               frame_err,
  output logic                               overrun,
  output logic                               parity_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] HALF_T   = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_T   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and falling-edge detector
  // ---------------------------------------------------------------------------
  logic       sync1_reg;
  logic       sync2_reg;
  logic [1:0] fill_reg;
  logic       prev_reg;
  logic       fall_edge;

  // prev_reg only records highs that came through the synchroniser after reset,
  // so the reset value of the flops can never fake a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      fill_reg  <= 2'b00;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= rx;
      sync2_reg <= sync1_reg;
      fill_reg  <= {fill_reg[0], 1'b1};
      prev_reg  <= fill_reg[1] & sync2_reg;
    end
  end

  assign fall_edge = prev_reg & ~sync2_reg;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t               state_reg, state_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 push_req;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_reg, overrun_next;
`ifdef UART_RX_PARITY_EN
  localparam logic ODD_BIT = (PARITY_ODD != 0);
  logic                 par_bad_reg, par_bad_next;
  logic                 parity_err_reg, parity_err_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      bit_reg       <= '0;
      data_reg      <= '0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      bit_reg       <= bit_next;
      data_reg      <= data_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= par_bad_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg + 1'b1;
    bit_next       = bit_reg;
    data_next      = data_reg;
    push_req       = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_next    = par_bad_reg;
    parity_err_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        bit_next   = '0;
        if (fall_edge) state_next = START;
      end
      START: begin
        // Mid-start-bit check; a line already back high was only a glitch.
        if (timer_reg == HALF_T) begin
          timer_next = '0;
          state_next = sync2_reg ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_reg == FULL_T) begin
          timer_next = '0;
          data_next  = {sync2_reg, data_reg[DATA_BITS-1:1]};
          if (bit_reg == LAST_BIT) begin
            bit_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer_reg == FULL_T) begin
          timer_next      = '0;
          par_bad_next    = sync2_reg ^ (^data_reg) ^ ODD_BIT;
          parity_err_next = sync2_reg ^ (^data_reg) ^ ODD_BIT;
          state_next      = STOP;
        end
      end
`endif
      STOP: begin
        if (timer_reg == FULL_T) begin
          timer_next = '0;
          if (sync2_reg) begin
`ifdef UART_RX_PARITY_EN
            push_req = ~par_bad_reg;
`else
            push_req = 1'b1;
`endif
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end
      end
      BREAK: begin
        timer_next = '0;
        if (sync2_reg) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 full;
  logic                 pop;
  logic                 wr_en;

  assign full    = (count_reg == DEPTH_C);
  assign m_valid = (count_reg != '0);
  assign pop     = m_valid & m_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en        = push_req & (~full | pop);
  assign overrun_next = push_req & full & ~pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr_reg] <= data_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign m_data    = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule
